// File: rtl/riscv_lsu_resp_if.sv
// rtl/riscv_lsu_resp_if.sv - dmem request/response bus between LSU, memory and response stage
interface riscv_lsu_resp_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_we;
  logic [2:0]      req_size;
  logic            req_unsigned;
  logic [2:0]      req_adr_lsb;
  logic [4:0]      req_rd;
  logic            req_full;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_q;
  logic            dmem_misaligned;
  logic            dmem_page_fault;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_adr_lsb, req_rd,
    output dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault,
    input  req_full
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_adr_lsb, req_rd,
    input  dmem_ack, dmem_q, dmem_misaligned, dmem_page_fault,
    output req_full
  );
endinterface

// File: rtl/riscv_lsu_resp.sv
// rtl/riscv_lsu_resp.sv - in-order dmem response tracker with load align/extend and flush drain
module riscv_lsu_resp #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  riscv_lsu_resp_if.slave            bus,
  input  logic                       flush,
  output logic                       ld_valid,
  output logic [XLEN-1:0]            ld_data,
  output logic [4:0]                 ld_rd,
  output logic                       st_done,
  output logic                       exc_misaligned,
  output logic                       exc_page_fault,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       proto_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(XLEN);

  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic       uns;
    logic [2:0] adr_lsb;
    logic [4:0] rd;
  } entry_t;

  entry_t          q_mem [DEPTH];
  entry_t          head;
  entry_t          new_entry;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, drop_cnt, used;
  logic            ack_drop, ack_live, ack_orphan, push, out_fire, any_fault;
  logic [5:0]      shift_full;
  logic [SW-1:0]   shift;
  logic [XLEN-1:0] raw;
  logic [63:0]     raw64, ext64;
  logic [XLEN-1:0] ld_next;

  assign head      = q_mem[rd_ptr];
  assign new_entry = '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                       adr_lsb: bus.req_adr_lsb, rd: bus.req_rd};

  // Stale acks from flushed requests are consumed before any live entry.
  assign ack_drop   = bus.dmem_ack && (drop_cnt != '0);
  assign ack_live   = bus.dmem_ack && (drop_cnt == '0) && (count != '0);
  assign ack_orphan = bus.dmem_ack && (drop_cnt == '0) && (count == '0);

  assign used         = count + drop_cnt;
  assign bus.req_full = (used >= CW'(DEPTH));
  assign outstanding  = count;

  // A full queue still accepts a request in the cycle an ack frees a slot.
  assign push     = bus.req_valid && !flush && (!bus.req_full || ack_drop || ack_live);
  assign out_fire = ack_live && !flush;
  assign any_fault = bus.dmem_misaligned || bus.dmem_page_fault;

  always_comb begin
    shift_full = {head.adr_lsb, 3'b000};
    shift      = shift_full[SW-1:0];
    raw        = bus.dmem_q >> shift;
    raw64      = 64'(raw);
    ext64      = '0;
    case (head.size)
      3'b000:  ext64 = {{56{!head.uns && raw64[7]}},  raw64[7:0]};
      3'b001:  ext64 = {{48{!head.uns && raw64[15]}}, raw64[15:0]};
      3'b010:  ext64 = {{32{!head.uns && raw64[31]}}, raw64[31:0]};
      3'b011:  ext64 = (XLEN == 64) ? raw64 : 64'd0;
      default: ext64 = '0;
    endcase
    ld_next = ext64[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr   <= wr_ptr;
        count    <= '0;
        drop_cnt <= drop_cnt + count - CW'(ack_drop || ack_live);
      end else begin
        wr_ptr   <= wr_ptr + PW'(push);
        rd_ptr   <= rd_ptr + PW'(ack_live);
        count    <= count + CW'(push) - CW'(ack_live);
        drop_cnt <= drop_cnt - CW'(ack_drop);
      end
      if ((bus.req_valid && !flush && !push) || ack_orphan) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_valid       <= 1'b0;
      ld_data        <= '0;
      ld_rd          <= '0;
      st_done        <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_page_fault <= 1'b0;
    end else begin
      ld_valid       <= out_fire && !head.we;
      st_done        <= out_fire && head.we;
      exc_misaligned <= out_fire && bus.dmem_misaligned;
      exc_page_fault <= out_fire && bus.dmem_page_fault;
      if (out_fire && !head.we) begin
        ld_data <= any_fault ? '0 : ld_next;
        ld_rd   <= head.rd;
      end
    end
  end
endmodule

// File: tb/tb_riscv_lsu_resp.sv
// tb/tb_riscv_lsu_resp.sv - directed bench for riscv_lsu_resp at XLEN=64 and XLEN=32
module tb_riscv_lsu_resp;
  logic clk = 1'b0;
  logic rstn, flush;
  int   n_cmp = 0;
  int   n_err = 0;

  riscv_lsu_resp_if #(.XLEN(64)) b64 ();
  riscv_lsu_resp_if #(.XLEN(32)) b32 ();

  logic        v64, sd64, em64, ep64, pe64;
  logic [63:0] d64;
  logic [4:0]  rd64;
  logic [1:0]  os64;
  logic        v32, sd32, em32, ep32, pe32;
  logic [31:0] d32;
  logic [4:0]  rd32;
  logic [1:0]  os32;

  riscv_lsu_resp #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rstn(rstn), .bus(b64), .flush(flush),
    .ld_valid(v64), .ld_data(d64), .ld_rd(rd64), .st_done(sd64),
    .exc_misaligned(em64), .exc_page_fault(ep64), .outstanding(os64), .proto_err(pe64)
  );

  riscv_lsu_resp #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rstn(rstn), .bus(b32), .flush(1'b0),
    .ld_valid(v32), .ld_data(d32), .ld_rd(rd32), .st_done(sd32),
    .exc_misaligned(em32), .exc_page_fault(ep32), .outstanding(os32), .proto_err(pe32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] size, input logic uns,
                       input logic [2:0] adr, input logic [4:0] rd);
    b64.req_valid = 1'b1; b64.req_we = we; b64.req_size = size;
    b64.req_unsigned = uns; b64.req_adr_lsb = adr; b64.req_rd = rd;
    tick();
    b64.req_valid = 1'b0;
  endtask

  task automatic ack(input logic [63:0] q, input logic mis, input logic pf);
    b64.dmem_ack = 1'b1; b64.dmem_q = q; b64.dmem_misaligned = mis; b64.dmem_page_fault = pf;
    tick();
    b64.dmem_ack = 1'b0; b64.dmem_misaligned = 1'b0; b64.dmem_page_fault = 1'b0;
  endtask

  task automatic load32(input logic [2:0] size, input logic [2:0] adr, input logic [4:0] rd,
                        input logic [31:0] q);
    b32.req_valid = 1'b1; b32.req_we = 1'b0; b32.req_size = size;
    b32.req_unsigned = 1'b0; b32.req_adr_lsb = adr; b32.req_rd = rd;
    tick();
    b32.req_valid = 1'b0;
    b32.dmem_ack = 1'b1; b32.dmem_q = q;
    tick();
    b32.dmem_ack = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_unsigned = 0;
    b64.req_adr_lsb = 0; b64.req_rd = 0; b64.dmem_ack = 0; b64.dmem_q = 0;
    b64.dmem_misaligned = 0; b64.dmem_page_fault = 0;
    b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_unsigned = 0;
    b32.req_adr_lsb = 0; b32.req_rd = 0; b32.dmem_ack = 0; b32.dmem_q = 0;
    b32.dmem_misaligned = 0; b32.dmem_page_fault = 0;
    tick(); tick();
    check("rst_ld_valid", v64, 0);
    check("rst_ld_data", d64, 0);
    check("rst_st_done", sd64, 0);
    check("rst_outstanding", os64, 0);
    check("rst_req_full", b64.req_full, 0);
    check("rst_proto_err", pe64, 0);
    rstn = 1'b1;
    tick();

    // Sign/zero extension and lane alignment.
    issue(0, 3'b000, 0, 3'd5, 5'd7);
    ack(64'h0000_9A00_0000_0000, 0, 0);
    check("lb_valid", v64, 1);
    check("lb_rd", rd64, 7);
    check("lb_data", d64, 64'hFFFF_FFFF_FFFF_FF9A);
    tick();
    check("lb_pulse", v64, 0);
    issue(0, 3'b000, 1, 3'd5, 5'd7);
    ack(64'h0000_9A00_0000_0000, 0, 0);
    check("lbu_data", d64, 64'h0000_0000_0000_009A);
    issue(0, 3'b001, 0, 3'd6, 5'd8);
    ack(64'h8001_1234_5678_9ABC, 0, 0);
    check("lh_data", d64, 64'hFFFF_FFFF_FFFF_8001);
    issue(0, 3'b010, 1, 3'd4, 5'd9);
    ack(64'hF000_0001_DEAD_BEEF, 0, 0);
    check("lwu_data", d64, 64'h0000_0000_F000_0001);
    issue(0, 3'b010, 0, 3'd4, 5'd9);
    ack(64'hF000_0001_DEAD_BEEF, 0, 0);
    check("lw_data", d64, 64'hFFFF_FFFF_F000_0001);
    issue(0, 3'b011, 0, 3'd0, 5'd10);
    ack(64'h8123_4567_89AB_CDEF, 0, 0);
    check("ld_data", d64, 64'h8123_4567_89AB_CDEF);

    load32(3'b010, 3'd0, 5'd10, 32'h8765_4321);
    check("x32_lw_valid", v32, 1);
    check("x32_lw_rd", rd32, 10);
    check("x32_lw_data", d32, 64'h8765_4321);
    load32(3'b001, 3'd6, 5'd11, 32'h8001_1234);
    check("x32_lh_data", d32, 64'hFFFF_8001);
    load32(3'b011, 3'd0, 5'd12, 32'h1234_5678);
    check("x32_ld_zero", d32, 0);

    // Fill, overflow attempt, then simultaneous ack and push.
    issue(0, 3'b000, 1, 3'd0, 5'd1);
    issue(0, 3'b001, 1, 3'd0, 5'd2);
    check("fill_full", b64.req_full, 1);
    check("fill_outstanding", os64, 2);
    issue(0, 3'b000, 1, 3'd0, 5'd3);
    check("ovf_proto_err", pe64, 1);
    check("ovf_outstanding", os64, 2);
    b64.req_valid = 1; b64.req_we = 0; b64.req_size = 3'b000;
    b64.req_unsigned = 1; b64.req_adr_lsb = 3'd1; b64.req_rd = 5'd4;
    b64.dmem_ack = 1; b64.dmem_q = 64'h0000_0000_0000_BB11;
    tick();
    b64.req_valid = 0; b64.dmem_ack = 0;
    check("pp_outstanding", os64, 2);
    check("pp_rd", rd64, 1);
    check("pp_data", d64, 64'h11);
    ack(64'h0000_0000_0000_CC22, 0, 0);
    check("ord2_rd", rd64, 2);
    check("ord2_data", d64, 64'hCC22);
    ack(64'h0000_0000_0000_3300, 0, 0);
    check("ord3_rd", rd64, 4);
    check("ord3_data", d64, 64'h33);
    check("drain_outstanding", os64, 0);

    // Store completion with fault, then faulted load.
    issue(1, 3'b010, 0, 3'd0, 5'd0);
    ack(64'h0, 0, 1);
    check("st_done", sd64, 1);
    check("st_exc_pf", ep64, 1);
    check("st_exc_mis", em64, 0);
    check("st_no_ld_valid", v64, 0);
    check("st_ld_data_hold", d64, 64'h33);
    issue(0, 3'b010, 0, 3'd1, 5'd9);
    ack(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    check("mis_valid", v64, 1);
    check("mis_exc", em64, 1);
    check("mis_data", d64, 0);
    check("mis_rd", rd64, 9);

    // Flush with two loads in flight; stale acks must be swallowed.
    issue(0, 3'b000, 0, 3'd0, 5'd3);
    issue(0, 3'b000, 0, 3'd0, 5'd4);
    flush = 1;
    tick();
    flush = 0;
    check("fl_outstanding", os64, 0);
    check("fl_full", b64.req_full, 1);
    ack(64'h55, 0, 0);
    check("fl_ack1_quiet", v64, 0);
    check("fl_ack1_full", b64.req_full, 0);
    ack(64'h66, 0, 0);
    check("fl_ack2_quiet", v64, 0);
    issue(0, 3'b000, 0, 3'd0, 5'd12);
    ack(64'h7F, 0, 0);
    check("fl_new_valid", v64, 1);
    check("fl_new_rd", rd64, 12);
    check("fl_new_data", d64, 64'h7F);

    // Asynchronous reset with one entry outstanding.
    issue(0, 3'b000, 0, 3'd0, 5'd5);
    check("mid_outstanding", os64, 1);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_outstanding", os64, 0);
    check("mid_rst_ld_data", d64, 0);
    check("mid_rst_ld_rd", rd64, 0);
    check("mid_rst_proto_err", pe64, 0);
    rstn = 1'b1;
    tick();
    ack(64'h1, 0, 0);
    check("spurious_proto_err", pe64, 1);
    check("spurious_no_valid", v64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
